// File: rtl/log_window_gen.sv
// Streaming 5x5 window generator for the LoG edge stage: four line buffers plus a
// 5x5 shift window, emitting only fully populated interior neighbourhoods.
module log_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_start,
    input  logic [7:0]   pixel_in,
    input  logic         pixel_valid,
    output logic [199:0] window_out,
    output logic         window_valid,
    output logic         frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // Handshake: pixel_in is consumed on every edge where pixel_valid=1 (no backpressure);
    // window_valid is a one-cycle strobe and the consumer must take window_out on it.

    logic [CW-1:0]  col_q, col_d, col_eff;
    logic [RW-1:0]  row_q, row_d, row_eff;
    logic [199:0]   win_q, win_d;
    logic           wv_q, wv_d;
    logic           fd_q, fd_d;

    logic [7:0]     lb0_mem [IMG_WIDTH];
    logic [7:0]     lb1_mem [IMG_WIDTH];
    logic [7:0]     lb2_mem [IMG_WIDTH];
    logic [7:0]     lb3_mem [IMG_WIDTH];
    logic [7:0]     lb0_rd, lb1_rd, lb2_rd, lb3_rd;

    always_comb begin
        col_eff = frame_start ? '0 : col_q;
        row_eff = frame_start ? '0 : row_q;

        // Combinational reads see the pre-edge contents, giving read-before-write.
        lb0_rd  = lb0_mem[col_eff];
        lb1_rd  = lb1_mem[col_eff];
        lb2_rd  = lb2_mem[col_eff];
        lb3_rd  = lb3_mem[col_eff];

        col_d   = col_eff;
        row_d   = row_eff;
        win_d   = win_q;
        wv_d    = 1'b0;
        fd_d    = 1'b0;

        if (pixel_valid) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[8*(5*r+c) +: 8] = win_q[8*(5*r+c+1) +: 8];
                end
            end
            win_d[8*4  +: 8] = lb3_rd;
            win_d[8*9  +: 8] = lb2_rd;
            win_d[8*14 +: 8] = lb1_rd;
            win_d[8*19 +: 8] = lb0_rd;
            win_d[8*24 +: 8] = pixel_in;

            wv_d = (row_eff >= RW'(4)) && (col_eff >= CW'(4));
            fd_d = (row_eff == RW'(IMG_HEIGHT-1)) && (col_eff == CW'(IMG_WIDTH-1));

            if (col_eff == CW'(IMG_WIDTH-1)) begin
                col_d = '0;
                row_d = (row_eff == RW'(IMG_HEIGHT-1)) ? '0 : row_eff + RW'(1);
            end else begin
                col_d = col_eff + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            wv_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            wv_q  <= wv_d;
            fd_q  <= fd_d;
        end
    end

    // Line buffers carry no reset; stale contents never reach a valid window.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb3_mem[col_eff] <= lb2_rd;
            lb2_mem[col_eff] <= lb1_rd;
            lb1_mem[col_eff] <= lb0_rd;
            lb0_mem[col_eff] <= pixel_in;
        end
    end

    assign window_out   = win_q;
    assign window_valid = wv_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_log_window_gen.sv
// Bench for log_window_gen: an 8x8 and a 5x5 instance driven against an image-array
// reference model that rebuilds each expected window from stored pixel positions.
module tb_log_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         fs8, pv8, wv8, fd8;
    logic [7:0]   px8;
    logic [199:0] win8;
    logic         fs5, pv5, wv5, fd5;
    logic [7:0]   px5;
    logic [199:0] win5;

    log_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs8), .pixel_in(px8), .pixel_valid(pv8),
        .window_out(win8), .window_valid(wv8), .frame_done(fd8)
    );

    log_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs5), .pixel_in(px5), .pixel_valid(pv5),
        .window_out(win5), .window_valid(wv5), .frame_done(fd5)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic         sel5;
    int           m_w, m_h, m_col, m_row;
    logic [7:0]   img [8][8];
    logic [199:0] exp_win;
    logic         exp_wv, exp_fd, hold_known;
    logic [199:0] exp_q [$];

    logic [199:0] obs_win;
    logic         obs_wv, obs_fd;
    always_comb begin
        obs_win = sel5 ? win5 : win8;
        obs_wv  = sel5 ? wv5  : wv8;
        obs_fd  = sel5 ? fd5  : fd8;
    end

    task automatic model_reset();
        m_col = 0; m_row = 0;
        exp_wv = 1'b0; exp_fd = 1'b0;
        exp_win = '0; hold_known = 1'b1;
        exp_q.delete();
    endtask

    // Drive one clock of stimulus to the selected instance and advance the model.
    task automatic step(input logic v, input logic fs, input logic [7:0] p);
        if (sel5) begin pv5 = v; fs5 = fs; px5 = p; end
        else      begin pv8 = v; fs8 = fs; px8 = p; end
        @(posedge clk);
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        if (fs) begin m_col = 0; m_row = 0; end
        if (v) begin
            img[m_row][m_col] = p;
            if (m_row >= 4 && m_col >= 4) begin
                for (int k = 0; k < 25; k++)
                    exp_win[8*k +: 8] = img[m_row-4+k/5][m_col-4+k%5];
                exp_wv = 1'b1;
                hold_known = 1'b1;
                exp_q.push_back(exp_win);
            end else begin
                hold_known = 1'b0;
            end
            if (m_col == m_w-1 && m_row == m_h-1) exp_fd = 1'b1;
            m_col++;
            if (m_col == m_w) begin
                m_col = 0;
                m_row++;
                if (m_row == m_h) m_row = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fs8 = 0; pv8 = 0; px8 = 0; fs5 = 0; pv5 = 0; px5 = 0;
        sel5 = 1'b0; m_w = 8; m_h = 8;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (win8 !== 200'd0) begin bad++; $display("FAIL reset_win8 got=%h want=0", win8); end
        total++; if (wv8 !== 1'b0 || fd8 !== 1'b0) begin bad++; $display("FAIL reset_flags8 got=%b%b want=00", wv8, fd8); end
        total++; if (win5 !== 200'd0 || wv5 !== 1'b0 || fd5 !== 1'b0) begin bad++; $display("FAIL reset_dut5 got=%h %b%b want=0 00", win5, wv5, fd5); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp(input string nm);
        int first = -1, cnt = 0, done_idx = -1;
        logic [199:0] w, first_win = '0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 8'(i));
            total++; if (obs_wv !== exp_wv) begin bad++; $display("FAIL %s_valid idx=%0d got=%b want=%b", nm, i, obs_wv, exp_wv); end
            total++; if (obs_fd !== exp_fd) begin bad++; $display("FAIL %s_done idx=%0d got=%b want=%b", nm, i, obs_fd, exp_fd); end
            if (exp_wv) begin
                w = exp_q.pop_front();
                total++; if (obs_win !== w) begin bad++; $display("FAIL %s_window idx=%0d got=%h want=%h", nm, i, obs_win, w); end
            end
            if (obs_wv === 1'b1) begin
                cnt++;
                if (first < 0) begin first = i; first_win = obs_win; end
            end
            if (obs_fd === 1'b1) done_idx = i;
        end
        total++; if (first != 36) begin bad++; $display("FAIL %s_first got=%0d want=36", nm, first); end
        total++; if (cnt != 16) begin bad++; $display("FAIL %s_count got=%0d want=16", nm, cnt); end
        total++; if (done_idx != 63) begin bad++; $display("FAIL %s_done_idx got=%0d want=63", nm, done_idx); end
        total++; if (first_win[103:96] !== 8'd18 || first_win[199:192] !== 8'd36 || first_win[7:0] !== 8'd0)
            begin bad++; $display("FAIL %s_first_win got=%h want centre=12 top=24 elem0=00 (hex)", nm, first_win); end
        step(1'b0, 1'b0, 8'd0);
        total++; if (obs_wv !== 1'b0 || obs_fd !== 1'b0) begin bad++; $display("FAIL %s_strobe_width got=%b%b want=00", nm, obs_wv, obs_fd); end
    endtask

    task automatic test_gapped();
        int i = 0, cyc = 0, first = -1, cnt = 0;
        logic v, prev_wv = 1'b0;
        logic [199:0] w;
        while (i < 64 && cyc < 1000) begin
            v = (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
            step(v, 1'b0, 8'(i));
            total++; if (obs_wv !== exp_wv) begin bad++; $display("FAIL gap_valid cyc=%0d got=%b want=%b", cyc, obs_wv, exp_wv); end
            total++; if (obs_fd !== exp_fd) begin bad++; $display("FAIL gap_done cyc=%0d got=%b want=%b", cyc, obs_fd, exp_fd); end
            if (exp_wv) begin
                w = exp_q.pop_front();
                total++; if (obs_win !== w) begin bad++; $display("FAIL gap_window cyc=%0d got=%h want=%h", cyc, obs_win, w); end
            end
            if (!v && hold_known) begin
                total++; if (obs_win !== exp_win) begin bad++; $display("FAIL gap_hold cyc=%0d got=%h want=%h", cyc, obs_win, exp_win); end
            end
            if (prev_wv && obs_wv === 1'b1) begin
                bad++; total++; $display("FAIL gap_strobe_len cyc=%0d got=2 want=1", cyc);
            end
            if (obs_wv === 1'b1) begin cnt++; if (first < 0) first = i; end
            prev_wv = (obs_wv === 1'b1);
            if (v) i++;
            cyc++;
        end
        total++; if (i != 64) begin bad++; $display("FAIL gap_budget got=%0d want=64 pixels", i); end
        total++; if (first != 36) begin bad++; $display("FAIL gap_first got=%0d want=36", first); end
        total++; if (cnt != 16) begin bad++; $display("FAIL gap_count got=%0d want=16", cnt); end
    endtask

    task automatic test_back_to_back();
        int early = 0, cnt = 0, first2 = -1;
        logic [199:0] w, win2 = '0;
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'b0, (i < 64) ? 8'(i) : 8'(100 + i - 64));
            total++; if (obs_wv !== exp_wv) begin bad++; $display("FAIL b2b_valid idx=%0d got=%b want=%b", i, obs_wv, exp_wv); end
            total++; if (obs_fd !== exp_fd) begin bad++; $display("FAIL b2b_done idx=%0d got=%b want=%b", i, obs_fd, exp_fd); end
            if (exp_wv) begin
                w = exp_q.pop_front();
                total++; if (obs_win !== w) begin bad++; $display("FAIL b2b_window idx=%0d got=%h want=%h", i, obs_win, w); end
            end
            if (obs_wv === 1'b1) begin
                cnt++;
                if (i >= 64 && i < 96) early++;
                if (i >= 64 && first2 < 0) begin first2 = i; win2 = obs_win; end
            end
        end
        total++; if (first2 != 100) begin bad++; $display("FAIL b2b_first2 got=%0d want=100", first2); end
        total++; if (win2[103:96] !== 8'd118) begin bad++; $display("FAIL b2b_centre got=%0d want=118", win2[103:96]); end
        total++; if (early != 0) begin bad++; $display("FAIL b2b_early got=%0d want=0", early); end
        total++; if (cnt != 32) begin bad++; $display("FAIL b2b_count got=%0d want=32", cnt); end
    endtask

    task automatic test_frame_start();
        int first = -1, done_idx = -1, cnt = 0;
        logic [199:0] w;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int j = 0; j < 64; j++) begin
            step(1'b1, (j == 0), 8'(j));
            total++; if (obs_wv !== exp_wv) begin bad++; $display("FAIL fs_valid idx=%0d got=%b want=%b", j, obs_wv, exp_wv); end
            total++; if (obs_fd !== exp_fd) begin bad++; $display("FAIL fs_done idx=%0d got=%b want=%b", j, obs_fd, exp_fd); end
            if (exp_wv) begin
                w = exp_q.pop_front();
                total++; if (obs_win !== w) begin bad++; $display("FAIL fs_window idx=%0d got=%h want=%h", j, obs_win, w); end
            end
            if (obs_wv === 1'b1) begin cnt++; if (first < 0) first = j; end
            if (obs_fd === 1'b1 && done_idx < 0) done_idx = j;
        end
        total++; if (first != 36) begin bad++; $display("FAIL fs_first got=%0d want=36", first); end
        total++; if (done_idx != 63) begin bad++; $display("FAIL fs_done_idx got=%0d want=63", done_idx); end
        total++; if (cnt != 16) begin bad++; $display("FAIL fs_count got=%0d want=16", cnt); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'(i));
        pv8 = 1'b0;
        total++; if (wv8 !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", wv8); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (wv8 !== 1'b0 || fd8 !== 1'b0) begin bad++; $display("FAIL ar_flags got=%b%b want=00", wv8, fd8); end
        total++; if (win8 !== 200'd0) begin bad++; $display("FAIL ar_window got=%h want=0", win8); end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        test_ramp("ar_ramp");
    endtask

    task automatic test_max_values();
        int cnt = 0, at = -1, done_at = -1;
        sel5 = 1'b1; m_w = 5; m_h = 5;
        model_reset();
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b0, 8'hFF);
            total++; if (obs_wv !== exp_wv) begin bad++; $display("FAIL max_valid idx=%0d got=%b want=%b", i, obs_wv, exp_wv); end
            if (obs_wv === 1'b1) begin cnt++; at = i; end
            if (obs_fd === 1'b1) done_at = i;
        end
        total++; if (cnt != 1 || at != 24) begin bad++; $display("FAIL max_count got=%0d@%0d want=1@24", cnt, at); end
        total++; if (win5 !== {200{1'b1}}) begin bad++; $display("FAIL max_window got=%h want=all ones", win5); end
        total++; if (done_at != 24) begin bad++; $display("FAIL max_done got=%0d want=24", done_at); end
        step(1'b0, 1'b0, 8'd0);
        total++; if (wv5 !== 1'b0 || fd5 !== 1'b0) begin bad++; $display("FAIL max_after got=%b%b want=00", wv5, fd5); end
    endtask

    initial begin
        test_reset();
        test_ramp("ramp");
        test_gapped();
        test_back_to_back();
        test_frame_start();
        test_async_reset();
        test_max_values();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
